// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the decode-stage hazard controller.
package hazard_ctrl_pkg;

   localparam int DEF_STAGES   = 3;
   localparam int DEF_AW       = 5;
   localparam int DEF_TW       = 4;
   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;

   // Tuse value meaning "operand not read" at the default Tuse width
   localparam logic [DEF_TW-1:0] TUSE_UNUSED = '1;

   // Forward-select width: 0 = register file, k+1 = slot k
   function automatic int fwd_width(input int stages);
      return $clog2(stages + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_ctrl_slot.sv
// One scoreboard entry: holds an in-flight destination register, ages its
// Tnew for the next slot, and compares itself against the D-stage sources.
module hazard_slot #(
   parameter int AW = 5,
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_valid,
   input  logic [AW-1:0] load_addr,
   input  logic [TW-1:0] load_tnew,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   output logic          next_valid,
   output logic [AW-1:0] next_addr,
   output logic [TW-1:0] next_tnew,
   output logic          ready,
   output logic          match_rs,
   output logic          match_rt,
   output logic          haz_rs,
   output logic          haz_rt
);

   logic          valid;
   logic [AW-1:0] addr;
   logic [TW-1:0] tnew;

   // Capture whatever the previous stage (or the D stage) hands down
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         addr  <= '0;
         tnew  <= '0;
      end else begin
         valid <= load_valid;
         addr  <= load_addr;
         tnew  <= load_tnew;
      end
   end

   assign next_valid = valid;
   assign next_addr  = addr;
   assign next_tnew  = (tnew == '0) ? '0 : tnew - TW'(1);

   assign ready    = (tnew == '0);
   assign match_rs = valid & (addr == d_rs) & (d_rs != '0);
   assign match_rt = valid & (addr == d_rt) & (d_rt != '0);
   assign haz_rs   = match_rs & (tnew > d_tuse_rs) & ~(&d_tuse_rs);
   assign haz_rt   = match_rt & (tnew > d_tuse_rt) & ~(&d_tuse_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage Tnew/Tuse hazard controller: scoreboard of in-flight writes,
// stall/forward generation, and mult/div busy tracking.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int STAGES   = DEF_STAGES,
   parameter int AW       = DEF_AW,
   parameter int TW       = DEF_TW,
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int FW       = fwd_width(STAGES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          d_valid,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic          d_wr_en,
   input  logic [AW-1:0] d_wr_addr,
   input  logic [TW-1:0] d_tnew,
   input  logic          d_md_start,
   input  logic          d_md_div,
   input  logic          d_md_use,
   output logic          stall,
   output logic [FW-1:0] fwd_rs_sel,
   output logic [FW-1:0] fwd_rt_sel,
   output logic          md_busy,
   output logic          md_done
);

   localparam int CW = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

   // Chain index k feeds slot k; index k+1 is slot k's aged contents
   logic          chain_valid [STAGES+1];
   logic [AW-1:0] chain_addr  [STAGES+1];
   logic [TW-1:0] chain_tnew  [STAGES+1];

   logic [STAGES-1:0] ready;
   logic [STAGES-1:0] match_rs;
   logic [STAGES-1:0] match_rt;
   logic [STAGES-1:0] haz_rs;
   logic [STAGES-1:0] haz_rt;

   logic          rs_haz;
   logic          rt_haz;
   logic          md_haz;
   logic          e_md;
   logic          e_md_div;
   logic [CW-1:0] md_cnt;

   assign chain_valid[0] = d_valid & d_wr_en & (d_wr_addr != '0) & ~stall;
   assign chain_addr[0]  = d_wr_addr;
   assign chain_tnew[0]  = d_tnew;

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      hazard_slot #(.AW(AW), .TW(TW)) u_slot (
         .clk        (clk),
         .rst_n      (rst_n),
         .load_valid (chain_valid[k]),
         .load_addr  (chain_addr[k]),
         .load_tnew  (chain_tnew[k]),
         .d_rs       (d_rs),
         .d_rt       (d_rt),
         .d_tuse_rs  (d_tuse_rs),
         .d_tuse_rt  (d_tuse_rt),
         .next_valid (chain_valid[k+1]),
         .next_addr  (chain_addr[k+1]),
         .next_tnew  (chain_tnew[k+1]),
         .ready      (ready[k]),
         .match_rs   (match_rs[k]),
         .match_rt   (match_rt[k]),
         .haz_rs     (haz_rs[k]),
         .haz_rt     (haz_rt[k])
      );
   end

   // Walk oldest to youngest so the youngest matching slot wins
   always_comb begin
      rs_haz     = 1'b0;
      rt_haz     = 1'b0;
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (match_rs[k]) begin
            rs_haz     = haz_rs[k];
            fwd_rs_sel = ready[k] ? FW'(k + 1) : '0;
         end
         if (match_rt[k]) begin
            rt_haz     = haz_rt[k];
            fwd_rt_sel = ready[k] ? FW'(k + 1) : '0;
         end
      end
   end

   // Note a mult/div entering E and which latency it needs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_md     <= 1'b0;
         e_md_div <= 1'b0;
      end else begin
         e_md     <= d_valid & d_md_start & ~stall;
         e_md_div <= d_md_div;
      end
   end

   // Busy counter loads on E entry, counts down, and flags the final tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt  <= '0;
         md_done <= 1'b0;
      end else begin
         md_done <= ~e_md & (md_cnt == CW'(1));
         if (e_md) begin
            md_cnt <= e_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
         end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
         end
      end
   end

   assign md_busy = (md_cnt != '0);
   assign md_haz  = d_valid & d_md_use & (md_busy | e_md);
   assign stall   = d_valid & (rs_haz | rt_haz | md_haz);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam logic [3:0] UN = TUSE_UNUSED;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       d_valid;
   logic [4:0] d_rs, d_rt, d_wr_addr;
   logic [3:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       d_wr_en, d_md_start, d_md_div, d_md_use;
   logic       stall, md_busy, md_done;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;

   int total_checks = 0;
   int bad_checks   = 0;
   int stall_cnt, busy_cnt, done_cnt;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_wr_en    (d_wr_en),
      .d_wr_addr  (d_wr_addr),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .d_md_use   (d_md_use),
      .stall      (stall),
      .fwd_rs_sel (fwd_rs_sel),
      .fwd_rt_sel (fwd_rt_sel),
      .md_busy    (md_busy),
      .md_done    (md_done)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [3:0] urs, input logic [3:0] urt,
                                input logic we, input logic [4:0] wa, input logic [3:0] tn,
                                input logic mds, input logic mdd, input logic mdu);
      d_valid    = v;
      d_rs       = rs;
      d_rt       = rt;
      d_tuse_rs  = urs;
      d_tuse_rt  = urt;
      d_wr_en    = we;
      d_wr_addr  = wa;
      d_tnew     = tn;
      d_md_start = mds;
      d_md_div   = mdd;
      d_md_use   = mdu;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 5'd0, 5'd0, UN, UN, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         applyIdle();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyIdle();
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_fwd_rs", fwd_rs_sel, 0);
      checkOutput("rst_fwd_rt", fwd_rt_sel, 0);
      checkOutput("rst_md_busy", md_busy, 0);
      checkOutput("rst_md_done", md_done, 0);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      flush();

      $display("[TB] load-use");
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 3, 2, 0, 0, 0);
      checkOutput("t1_lw_stall", stall, 0);
      nextCycle(); applyStimulus(1, 3, 0, 1, UN, 1, 4, 1, 0, 0, 0);
      checkOutput("t1_add_stall", stall, 1);
      checkOutput("t1_add_fwd_early", fwd_rs_sel, 0);
      nextCycle();
      checkOutput("t1_add_issue", stall, 0);
      checkOutput("t1_add_fwd_m", fwd_rs_sel, 0);
      nextCycle(); applyStimulus(1, 3, 0, 2, UN, 0, 0, 0, 0, 0, 0);
      checkOutput("t1_w_fwd", fwd_rs_sel, 3);
      checkOutput("t1_w_stall", stall, 0);
      flush();

      $display("[TB] alu chain");
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 5, 1, 0, 0, 0);
      nextCycle(); applyStimulus(1, 5, 0, 0, UN, 0, 0, 0, 0, 0, 0);
      checkOutput("t2_beq_stall", stall, 1);
      checkOutput("t2_beq_fwd_early", fwd_rs_sel, 0);
      nextCycle();
      checkOutput("t2_beq_go", stall, 0);
      checkOutput("t2_beq_fwd_m", fwd_rs_sel, 2);
      flush();

      $display("[TB] jal/jr and $0");
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 31, 0, 0, 0, 0);
      nextCycle(); applyStimulus(1, 31, 0, 0, UN, 0, 0, 0, 0, 0, 0);
      checkOutput("t3_jr_stall", stall, 0);
      checkOutput("t3_jr_fwd_e", fwd_rs_sel, 1);
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 0, 2, 0, 0, 0);
      checkOutput("t3_w0_stall", stall, 0);
      nextCycle(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t3_r0_stall", stall, 0);
      checkOutput("t3_r0_fwd_rs", fwd_rs_sel, 0);
      checkOutput("t3_r0_fwd_rt", fwd_rt_sel, 0);
      flush();

      $display("[TB] shadowing");
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 7, 0, 0, 0, 0);
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 7, 0, 0, 0, 0);
      nextCycle(); applyStimulus(1, 0, 7, UN, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4_fwd_rt_e", fwd_rt_sel, 1);
      checkOutput("t4_stall", stall, 0);
      checkOutput("t4_fwd_rs", fwd_rs_sel, 0);
      nextCycle();
      checkOutput("t4_fwd_rt_m", fwd_rt_sel, 2);
      nextCycle();
      checkOutput("t4_fwd_rt_w", fwd_rt_sel, 3);
      flush();
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 7, 0, 0, 0, 0);
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 7, 2, 0, 0, 0);
      nextCycle(); applyStimulus(1, 0, 7, UN, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("t4_young_busy_stall", stall, 1);
      checkOutput("t4_young_busy_fwd", fwd_rt_sel, 0);
      flush();

      $display("[TB] div then mflo");
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 0, 0, 0, 1, 1, 1);
      checkOutput("t5_div_stall", stall, 0);
      checkOutput("t5_div_busy", md_busy, 0);
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 8, 1, 0, 0, 1);
      stall_cnt = 0;
      busy_cnt  = 0;
      done_cnt  = 0;
      for (int i = 0; i < 40; i++) begin
         if (!stall) break;
         stall_cnt++;
         busy_cnt += int'(md_busy);
         done_cnt += int'(md_done);
         nextCycle();
         #1;
      end
      checkOutput("t5_stall_cycles", stall_cnt, 11);
      checkOutput("t5_busy_cycles", busy_cnt, 10);
      checkOutput("t5_early_done", done_cnt, 0);
      checkOutput("t5_done_pulse", md_done, 1);
      checkOutput("t5_busy_end", md_busy, 0);
      nextCycle(); applyIdle();
      checkOutput("t5_done_once", md_done, 0);
      flush();

      $display("[TB] reset during mult");
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 0, 0, 0, 1, 0, 1);
      checkOutput("t6_mult_stall", stall, 0);
      nextCycle(); applyStimulus(1, 0, 0, UN, UN, 1, 9, 2, 0, 0, 0);
      nextCycle(); applyStimulus(1, 9, 0, 0, UN, 0, 0, 0, 0, 0, 1);
      checkOutput("t6_busy_before", md_busy, 1);
      checkOutput("t6_stall_before", stall, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_busy_after", md_busy, 0);
      checkOutput("t6_stall_after", stall, 0);
      checkOutput("t6_fwd_after", fwd_rs_sel, 0);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      applyIdle();
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         nextCycle();
         #1;
         busy_cnt += int'(md_busy);
         done_cnt += int'(md_done);
      end
      checkOutput("t6_no_done", done_cnt, 0);
      checkOutput("t6_no_busy", busy_cnt, 0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
